// File: rtl/axi_tx_ctrl_regs.sv
// AXI4-Lite slave register file for the TX controller (S00_AXI).
// Holds NUM_REGS 32-bit control registers. Unmapped addresses are answered with SLVERR.
//
// Ports:
//   S_AXI_ACLK, S_AXI_ARESET   clock, synchronous active-high reset
//   S_AXI_AW*/W*/B*            write address, write data and write response channels
//   S_AXI_AR*/R*               read address and read data channels
//   reg_out                    {reg3, reg2, reg1, reg0}, straight from the register flops
//   wr_pulse                   one-cycle pulse for each mapped register written
module axi_tx_ctrl_regs #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
    parameter int unsigned NUM_REGS           = 4
) (
    input  logic                                   S_AXI_ACLK,
    input  logic                                   S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                             S_AXI_AWPROT,
    input  logic                                   S_AXI_AWVALID,
    output logic                                   S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                                   S_AXI_WVALID,
    output logic                                   S_AXI_WREADY,
    output logic [1:0]                             S_AXI_BRESP,
    output logic                                   S_AXI_BVALID,
    input  logic                                   S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                             S_AXI_ARPROT,
    input  logic                                   S_AXI_ARVALID,
    output logic                                   S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                             S_AXI_RRESP,
    output logic                                   S_AXI_RVALID,
    input  logic                                   S_AXI_RREADY,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]                    wr_pulse
);

    localparam int unsigned DW     = C_S_AXI_DATA_WIDTH;
    localparam int unsigned AW     = C_S_AXI_ADDR_WIDTH;
    localparam int unsigned STRB_W = DW / 8;
    localparam int unsigned IDX_W  = $clog2(NUM_REGS);
    localparam logic [AW-3:0] NUM_REGS_W = (AW-2)'(NUM_REGS);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {WIdle, WResp} w_state_e;
    typedef enum logic {RIdle, RData} r_state_e;

    // Register file
    logic [DW-1:0] regs_q [NUM_REGS];
    logic [DW-1:0] regs_d [NUM_REGS];

    // Write path state
    w_state_e          w_state_q, w_state_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic              aw_ready_q, aw_ready_d;
    logic              w_ready_q, w_ready_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic [AW-1:0]     awaddr_q, awaddr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [STRB_W-1:0] wstrb_q, wstrb_d;
    logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;

    // Read path state
    r_state_e      r_state_q, r_state_d;
    logic          ar_ready_q, ar_ready_d;
    logic          rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [1:0]    rresp_q, rresp_d;

    logic              aw_hs, w_hs, aw_have, w_have, commit;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic [STRB_W-1:0] wr_strb;
    logic              wr_mapped, rd_mapped;
    logic [IDX_W-1:0]  wr_idx, rd_idx;
    logic              unused_ok;

    assign aw_hs   = S_AXI_AWVALID && aw_ready_q;
    assign w_hs    = S_AXI_WVALID && w_ready_q;
    assign aw_have = aw_done_q || aw_hs;
    assign w_have  = w_done_q || w_hs;

    // Whichever channel handshakes on the commit edge is taken live; the other comes from
    // the holding register.
    assign wr_addr   = aw_hs ? S_AXI_AWADDR : awaddr_q;
    assign wr_data   = w_hs ? S_AXI_WDATA : wdata_q;
    assign wr_strb   = w_hs ? S_AXI_WSTRB : wstrb_q;
    assign wr_mapped = wr_addr[AW-1:2] < NUM_REGS_W;
    assign wr_idx    = wr_addr[IDX_W+1:2];

    assign rd_mapped = S_AXI_ARADDR[AW-1:2] < NUM_REGS_W;
    assign rd_idx    = S_AXI_ARADDR[IDX_W+1:2];

    // Protection bits and the byte offset within a word carry no meaning here.
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_addr[1:0], S_AXI_ARADDR[1:0]};

    // Write channel next state
    always_comb begin
        w_state_d  = w_state_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        aw_ready_d = aw_ready_q;
        w_ready_d  = w_ready_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        wr_pulse_d = '0;
        commit     = 1'b0;
        unique case (w_state_q)
            WIdle: begin
                aw_done_d  = aw_have;
                w_done_d   = w_have;
                aw_ready_d = !aw_have;
                w_ready_d  = !w_have;
                if (aw_hs) begin
                    awaddr_d = S_AXI_AWADDR;
                end
                if (w_hs) begin
                    wdata_d = S_AXI_WDATA;
                    wstrb_d = S_AXI_WSTRB;
                end
                if (aw_have && w_have) begin
                    commit     = 1'b1;
                    w_state_d  = WResp;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    aw_ready_d = 1'b0;
                    w_ready_d  = 1'b0;
                    bvalid_d   = 1'b1;
                    bresp_d    = wr_mapped ? RESP_OKAY : RESP_SLVERR;
                    if (wr_mapped) begin
                        wr_pulse_d[wr_idx] = 1'b1;
                    end
                end
            end
            WResp: begin
                if (S_AXI_BREADY) begin
                    w_state_d  = WIdle;
                    bvalid_d   = 1'b0;
                    aw_ready_d = 1'b1;
                    w_ready_d  = 1'b1;
                end
            end
        endcase
    end

    // Register update: byte-lane merge on commit to a mapped address
    always_comb begin
        regs_d = regs_q;
        if (commit && wr_mapped) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (wr_strb[b]) begin
                    regs_d[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
                end
            end
        end
    end

    // Read channel next state; reads see regs_q, so a same-edge write is not visible yet.
    always_comb begin
        r_state_d  = r_state_q;
        ar_ready_d = ar_ready_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        unique case (r_state_q)
            RIdle: begin
                ar_ready_d = 1'b1;
                if (S_AXI_ARVALID && ar_ready_q) begin
                    r_state_d  = RData;
                    ar_ready_d = 1'b0;
                    rvalid_d   = 1'b1;
                    rdata_d    = rd_mapped ? regs_q[rd_idx] : '0;
                    rresp_d    = rd_mapped ? RESP_OKAY : RESP_SLVERR;
                end
            end
            RData: begin
                if (S_AXI_RREADY) begin
                    r_state_d  = RIdle;
                    rvalid_d   = 1'b0;
                    ar_ready_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            w_state_q  <= WIdle;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= '0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            wr_pulse_q <= '0;
            r_state_q  <= RIdle;
            ar_ready_q <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= '0;
        end else begin
            regs_q     <= regs_d;
            w_state_q  <= w_state_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            aw_ready_q <= aw_ready_d;
            w_ready_q  <= w_ready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            wr_pulse_q <= wr_pulse_d;
            r_state_q  <= r_state_d;
            ar_ready_q <= ar_ready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_out
        assign reg_out[i*DW +: DW] = regs_q[i];
    end

    assign S_AXI_AWREADY = aw_ready_q;
    assign S_AXI_WREADY  = w_ready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = ar_ready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign wr_pulse      = wr_pulse_q;

endmodule

// File: tb/tb_axi_tx_ctrl_regs.sv
// Self-checking bench for axi_tx_ctrl_regs: directed scenarios plus random traffic,
// with expected responses queued at issue time and popped by an independent monitor.
module tb_axi_tx_ctrl_regs;

    logic         clk = 1'b0;
    logic         areset;
    logic [4:0]   awaddr;
    logic [2:0]   awprot;
    logic         awvalid, awready;
    logic [31:0]  wdata;
    logic [3:0]   wstrb;
    logic         wvalid, wready;
    logic [1:0]   bresp;
    logic         bvalid, bready;
    logic [4:0]   araddr;
    logic [2:0]   arprot;
    logic         arvalid, arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid, rready;
    logic [127:0] reg_out;
    logic [3:0]   wr_pulse;

    axi_tx_ctrl_regs dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (areset),
        .S_AXI_AWADDR (awaddr),
        .S_AXI_AWPROT (awprot),
        .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready),
        .S_AXI_WDATA  (wdata),
        .S_AXI_WSTRB  (wstrb),
        .S_AXI_WVALID (wvalid),
        .S_AXI_WREADY (wready),
        .S_AXI_BRESP  (bresp),
        .S_AXI_BVALID (bvalid),
        .S_AXI_BREADY (bready),
        .S_AXI_ARADDR (araddr),
        .S_AXI_ARPROT (arprot),
        .S_AXI_ARVALID(arvalid),
        .S_AXI_ARREADY(arready),
        .S_AXI_RDATA  (rdata),
        .S_AXI_RRESP  (rresp),
        .S_AXI_RVALID (rvalid),
        .S_AXI_RREADY (rready),
        .reg_out      (reg_out),
        .wr_pulse     (wr_pulse)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the four registers as plain words
    logic [31:0] model [4];

    // Scoreboard queues
    logic [1:0]  bq [$];
    logic [33:0] rq [$];   // {rresp, rdata}
    logic [3:0]  pq [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] model_flat();
        return {model[3], model[2], model[1], model[0]};
    endfunction

    // Monitor: pops and compares whenever the DUT presents a response or a pulse
    always @(negedge clk) begin
        if (!areset) begin
            if (bvalid && bready) begin
                if (bq.size() == 0) check("b_unexpected", 128'(bq.size()), 128'd1);
                else check("bresp", 128'(bresp), 128'(bq.pop_front()));
            end
            if (rvalid && rready) begin
                if (rq.size() == 0) check("r_unexpected", 128'(rq.size()), 128'd1);
                else check("rresp_rdata", 128'({rresp, rdata}), 128'(rq.pop_front()));
            end
            if (wr_pulse != 4'b0) begin
                if (pq.size() == 0) check("pulse_unexpected", 128'(wr_pulse), 128'd0);
                else check("wr_pulse", 128'(wr_pulse), 128'(pq.pop_front()));
            end
        end
    end

    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input int hold,
                            input bit wait_resp);
        bit aw_ok = 0, w_ok = 0, aw_f, w_f;
        int cyc = 0;
        logic [1:0] exp_resp;
        if (a < 5'd16) begin
            for (int b = 0; b < 4; b++) if (s[b]) model[a[3:2]][8*b +: 8] = d[8*b +: 8];
            pq.push_back(4'b0001 << a[3:2]);
            exp_resp = 2'b00;
        end else begin
            exp_resp = 2'b10;
        end
        if (wait_resp) bq.push_back(exp_resp);
        bready = 1'b0;
        while (!(aw_ok && w_ok) && cyc < 64) begin
            if (!aw_ok && cyc >= aw_dly) begin awvalid = 1'b1; awaddr = a; end
            if (!w_ok && cyc >= w_dly) begin wvalid = 1'b1; wdata = d; wstrb = s; end
            @(negedge clk);
            aw_f = awvalid && awready;
            w_f  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_f) begin aw_ok = 1; awvalid = 1'b0; awaddr = 5'($urandom); end
            if (w_f) begin w_ok = 1; wvalid = 1'b0; wdata = $urandom; wstrb = 4'($urandom); end
            cyc++;
        end
        check("write_handshake", 128'({aw_ok, w_ok}), 128'(2'b11));
        check("bvalid_latency", 128'(bvalid), 128'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("b_hold", 128'({bvalid, bresp, awready, wready}), 128'({1'b1, exp_resp, 2'b00}));
        end
        if (wait_resp) begin
            bready = 1'b1;
            @(posedge clk); #1;
            bready = 1'b0;
            check("reg_out_after_write", reg_out, model_flat());
        end
    endtask

    task automatic do_read(input logic [4:0] a, input int hold);
        bit ok = 0, f;
        int cyc = 0;
        logic [33:0] exp;
        exp = (a < 5'd16) ? {2'b00, model[a[3:2]]} : {2'b10, 32'h0};
        rq.push_back(exp);
        rready = 1'b0;
        arvalid = 1'b1;
        araddr = a;
        while (!ok && cyc < 64) begin
            @(negedge clk);
            f = arvalid && arready;
            @(posedge clk); #1;
            if (f) ok = 1;
            cyc++;
        end
        arvalid = 1'b0;
        araddr = 5'($urandom);
        check("ar_handshake", 128'(ok), 128'd1);
        check("rvalid_latency", 128'(rvalid), 128'd1);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("r_hold", 128'({rvalid, arready, rresp, rdata}), 128'({2'b10, exp}));
        end
        rready = 1'b1;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) model[i] = 32'h0;
        awprot = 3'b0; arprot = 3'b0;
        areset = 1'b1;
        awvalid = 1'b1; awaddr = 5'h04;
        wvalid = 1'b1; wdata = 32'hDEADBEEF; wstrb = 4'hF;
        arvalid = 1'b1; araddr = 5'h04;
        bready = 1'b1; rready = 1'b1;

        // Reset held with requests pending: every output stays 0
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("reset_outputs",
                  128'({awready, wready, bvalid, bresp, arready, rvalid, rresp, rdata,
                        wr_pulse}), 128'd0);
            check("reset_reg_out", reg_out, 128'd0);
        end
        areset = 1'b0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        bready = 1'b0; rready = 1'b0;
        @(posedge clk); #1;
        check("ready_after_reset", 128'({awready, wready, arready, bvalid, rvalid}),
              128'(5'b11100));

        // Sequential write / readback
        for (int i = 0; i < 4; i++) do_write(5'(4 * i), 32'(i + 1), 4'hF, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) do_read(5'(4 * i), 0);
        check("reg_out_seq", reg_out, 128'h00000004_00000003_00000002_00000001);

        // Channel ordering: W three cycles ahead of AW, then AW ahead of W
        do_write(5'h08, 32'hA5A5A5A5, 4'hF, 3, 0, 0, 1);
        check("reg2_w_first", 128'(reg_out[95:64]), 128'hA5A5A5A5);
        do_write(5'h08, 32'h5A5A5A5A, 4'hF, 0, 3, 0, 1);
        check("reg2_aw_first", 128'(reg_out[95:64]), 128'h5A5A5A5A);

        // Byte strobes, including an all-zero strobe that still pulses
        do_write(5'h04, 32'h11223344, 4'hF, 0, 0, 0, 1);
        do_write(5'h05, 32'hAABBCCDD, 4'b0101, 0, 0, 0, 1);
        check("reg1_strb", 128'(reg_out[63:32]), 128'h11BB33DD);
        do_write(5'h06, 32'hFFFFFFFF, 4'b0000, 0, 0, 0, 1);
        check("reg1_strb0", 128'(reg_out[63:32]), 128'h11BB33DD);

        // Unmapped accesses with response backpressure
        do_write(5'h14, 32'hCAFEF00D, 4'hF, 0, 0, 5, 1);
        do_read(5'h1C, 5);
        do_read(5'h0F, 2);

        // Read and write commit on the same edge to reg0: read returns the old value
        rq.push_back({2'b00, model[0]});
        model[0] = 32'h55;
        pq.push_back(4'b0001);
        bq.push_back(2'b00);
        awvalid = 1'b1; awaddr = 5'h00;
        wvalid = 1'b1; wdata = 32'h55; wstrb = 4'hF;
        arvalid = 1'b1; araddr = 5'h00;
        @(negedge clk);
        check("concurrent_ready", 128'({awready, wready, arready}), 128'(3'b111));
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        check("concurrent_valid", 128'({bvalid, rvalid}), 128'(2'b11));
        bready = 1'b1; rready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0; rready = 1'b0;
        do_read(5'h00, 0);

        // Random traffic
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(1) == 1)
                do_write(5'($urandom_range(31)), $urandom, 4'($urandom),
                         $urandom_range(3), $urandom_range(3), $urandom_range(2), 1);
            else
                do_read(5'($urandom_range(31)), $urandom_range(2));
        end
        check("queues_drained", 128'(bq.size() + rq.size() + pq.size()), 128'd0);

        // Reset while a write response is pending
        do_write(5'h00, 32'h12345678, 4'hF, 0, 0, 0, 0);
        @(posedge clk); #1;
        areset = 1'b1;
        @(posedge clk); #1;
        areset = 1'b0;
        for (int i = 0; i < 4; i++) model[i] = 32'h0;
        check("reset_mid_bvalid", 128'({bvalid, wr_pulse}), 128'd0);
        check("reset_mid_reg_out", reg_out, 128'd0);
        do_read(5'h00, 0);
        check("queues_drained_end", 128'(bq.size() + rq.size() + pq.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_tx_ctrl_regs.md
Name: axi_tx_ctrl_regs

Overview:
- AXI4-Lite slave (responder) register file on the S00_AXI port of the TX controller.
- Accepts the single-beat writes and reads issued by the PS or by the master VIP, and holds four 32-bit control registers.
- Drives the register values and one-cycle write-strobe pulses into the TX datapath.
- Decodes out-of-range addresses and answers them with SLVERR.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported
C_S_AXI_ADDR_WIDTH, 5, byte address width; 0x00-0x0C are mapped, 0x10-0x1C are unmapped
NUM_REGS, 4, number of mapped 32-bit registers at word offsets 0..3

Ports:
S_AXI_ACLK  in  1  single clock for the whole block
S_AXI_ARESET  in  1  synchronous, active-high reset
S_AXI_AWADDR  in  5  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address ready
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte-lane enables
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data ready
S_AXI_BRESP  out  2  2'b00 OKAY, 2'b10 SLVERR
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response ready
S_AXI_ARADDR  in  5  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address ready
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data ready
reg_out  out  128  {reg3, reg2, reg1, reg0}, registered
wr_pulse  out  4  one-cycle pulse per register written

Behaviour:
- Reset: every output is 0 in the cycle after a reset edge. This covers READY, VALID, RESP, RDATA, reg_out and wr_pulse. Reset wins over any handshake on the same edge. An in-flight transaction is dropped and no response is issued.
- Write path, states W_IDLE and W_RESP.
  - In W_IDLE, AWREADY = 1 until an AW has been captured; WREADY = 1 until a W has been captured. AW and W may arrive in either order or together. The captured one is held while the block waits for the other.
  - On the edge where the second of the two handshakes completes, the write commits:
    - For a mapped address, each byte lane with a WSTRB bit set updates reg[AWADDR[3:2]]. wr_pulse[idx] = 1 for exactly the next cycle, even when WSTRB = 0.
    - For an unmapped address (AWADDR[4] = 1), no register changes and no pulse is generated.
    - BVALID = 1 from the next cycle. BRESP = OKAY for mapped, SLVERR for unmapped. Go to W_RESP.
  - In W_RESP, AWREADY = WREADY = 0. BVALID and BRESP are held stable until BREADY; the handshake edge returns the path to W_IDLE.
  - Minimum spacing is one write per 2 cycles when BREADY is tied high.
- Read path, states R_IDLE and R_DATA.
  - In R_IDLE, ARREADY = 1.
  - On the AR handshake edge, RDATA, RRESP and RVALID = 1 are registered and the path goes to R_DATA. Latency is one cycle from AR to RVALID.
  - Mapped address: RDATA = reg[ARADDR[3:2]], RRESP = OKAY. Unmapped: RDATA = 0, RRESP = SLVERR.
  - In R_DATA, ARREADY = 0. RDATA and RRESP are held until RREADY; then back to R_IDLE.
- The read and write paths are fully independent.
- A read that handshakes on the same edge as a write commit to the same register returns the pre-write value.
- Address bits [1:0] are ignored (no alignment error).
- reg_out tracks the registers with no extra delay beyond the commit edge.
- Protocol: VALID from the slave never drops without the matching READY, and the payload is stable while VALID is high.

Test Plan:
- Reset: hold S_AXI_ARESET for 10 cycles with AWVALID/ARVALID asserted -> all outputs 0, no BVALID or RVALID; AWREADY and ARREADY are 1 in the first cycle after release.
- Sequential write/readback:
  - Write 0x1, 0x2, 0x3, 0x4 to 0x00, 0x04, 0x08, 0x0C with WSTRB = 0xF -> each BRESP = OKAY; wr_pulse = 0001, 0010, 0100, 1000 in turn.
  - Read the same addresses -> RDATA = 0x1, 0x2, 0x3, 0x4, RRESP = OKAY.
  - reg_out = 0x00000004_00000003_00000002_00000001.
- Channel ordering:
  - W of 0xA5A5A5A5 presented 3 cycles before AW to 0x08 -> WREADY handshake first; BVALID one cycle after the AW handshake; reg2 = 0xA5A5A5A5.
  - Repeat with AW first -> same result.
- Byte strobes: reg1 = 0x11223344, then write 0xAABBCCDD to 0x04 with WSTRB = 0101 -> reg1 = 0x11BB33DD; with WSTRB = 0000 -> unchanged, OKAY, wr_pulse[1] = 1.
- Unmapped and backpressure:
  - Write to 0x14 -> BRESP = SLVERR, no register change, wr_pulse = 0.
  - Read 0x1C -> RDATA = 0, RRESP = SLVERR.
  - Hold BREADY/RREADY low for 5 cycles -> VALID and payload stable, AWREADY/WREADY/ARREADY = 0 throughout.
- Concurrency and reset mid-operation:
  - Read of 0x00 handshaking on the same edge as a commit of 0x55 to 0x00 (old value 0x1) -> RDATA = 0x1; a later read returns 0x55.
  - Assert reset while BVALID = 1 -> BVALID = 0 next cycle, reg0 = 0.
